// File: rtl/dpga_cfg_pkg.sv
// Shared DPGA configuration-chain constants and FSM encoding, common to the
// serializer and the receiving shift register so both agree on word size.
package dpga_cfg_pkg;

    localparam int DEF_WORD   = 8;
    localparam int DEF_NWORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } cfg_state_e;

    // Index counters keep at least one bit even for single-word frames.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/config_serializer_if.sv
// Parallel configuration-word handshake: source presents din/din_valid, sink
// answers with din_ready; a word moves on an edge with both high.
interface config_serializer_if #(
    parameter int WORD = dpga_cfg_pkg::DEF_WORD
);
    logic [WORD-1:0] din;
    logic            din_valid;
    logic            din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/config_serializer.sv
// Serializes config words MSB-first onto the chain, latch pulse after NWORDS words.
// First bit on sdo the cycle after transfer; din_ready only in IDLE (WORD+1 cycles/word).
module config_serializer
    import dpga_cfg_pkg::*;
#(
    parameter int WORD   = DEF_WORD,
    parameter int NWORDS = DEF_NWORDS
) (
    input  logic                             clk,
    input  logic                             reset,
    config_serializer_if.slave               cfg,
    output logic                             sdo,
    output logic                             shift_en,
    output logic                             latch,
    output logic                             busy,
    output logic [idx_width(NWORDS)-1:0]     word_idx
);

    localparam int IW = idx_width(NWORDS);
    localparam int BW = $clog2(WORD);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] LATCH = ST_LATCH;

    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD - 1);
    localparam logic [IW-1:0] LAST_WORD = IW'(NWORDS - 1);

    logic [1:0]      state;
    logic [BW-1:0]   bit_cnt;
    logic [WORD-1:0] shreg;
    logic [WORD-1:0] shreg_nxt;

    assign cfg.din_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    // The bit driven next is the MSB of the shifted register.
    assign shreg_nxt = shreg << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sdo      <= 1'b0;
            shift_en <= 1'b0;
            latch    <= 1'b0;
            word_idx <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg.din_valid) begin
                        shreg    <= cfg.din;
                        sdo      <= cfg.din[WORD-1];
                        shift_en <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bit_cnt != LAST_BIT) begin
                        shreg   <= shreg_nxt;
                        sdo     <= shreg_nxt[WORD-1];
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        sdo      <= 1'b0;
                        shift_en <= 1'b0;
                        if (word_idx == LAST_WORD) begin
                            state    <= LATCH;
                            latch    <= 1'b1;
                            word_idx <= '0;
                        end else begin
                            state    <= IDLE;
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end

                LATCH: begin
                    latch <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    sdo      <= 1'b0;
                    shift_en <= 1'b0;
                    latch    <= 1'b0;
                end
            endcase
        end
    end

endmodule
